// File: rtl/microcode_sequencer_stack.sv
// microcode_sequencer_stack: one FSM that owns the micro-PC, a microcode
// call/return stack, the memory-stall handshake, the instruction-fetch wait
// and the retired-instruction counter.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   enable                start request (IDLE only)
//   halt_request          halt check (IDLE and on uc_finish only)
//   dispatch_address      microcode entry point from the opcode translator
//   mem_ready             0 stalls microcode execution
//   uc_*, branch_taken    current microword fields, uc_target call/branch target
//   upc                   microcode ROM address
//   rom_read_enable       high in RUN and STALL
//   pc_enable, pc_load_n  one-cycle PC increment / active-low PC load strobes
//   state                 FSM state encoding
//   stack_level           call-stack occupancy
//   halted                high in HALTED
//   stack_overflow/underflow  sticky error flags
//   instr_retired         count of finished instructions (wraps)
module microcode_sequencer_stack #(
  parameter int unsigned UPC_WIDTH     = 16,
  parameter int unsigned STACK_DEPTH   = 4,
  parameter int unsigned FETCH_LATENCY = 1,
  parameter int unsigned COUNT_WIDTH   = 16,
  localparam int unsigned LVL_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   halt_request,
  input  logic [UPC_WIDTH-1:0]   dispatch_address,
  input  logic                   mem_ready,
  input  logic                   uc_finish,
  input  logic                   uc_jump,
  input  logic                   uc_call,
  input  logic                   uc_return,
  input  logic                   uc_branch,
  input  logic                   branch_taken,
  input  logic [UPC_WIDTH-1:0]   uc_target,
  output logic [UPC_WIDTH-1:0]   upc,
  output logic                   rom_read_enable,
  output logic                   pc_enable,
  output logic                   pc_load_n,
  output logic [2:0]             state,
  output logic [LVL_W-1:0]       stack_level,
  output logic                   halted,
  output logic                   stack_overflow,
  output logic                   stack_underflow,
  output logic [COUNT_WIDTH-1:0] instr_retired
);

  localparam int unsigned FW_W = 4;
  localparam logic [FW_W-1:0]  FETCH_LAT = FW_W'(FETCH_LATENCY);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DISPATCH   = 3'd2,
    ST_RUN        = 3'd3,
    ST_STALL      = 3'd4,
    ST_ADVANCE    = 3'd5,
    ST_HALTED     = 3'd6,
    ST_FAULT      = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [UPC_WIDTH-1:0]   upc_q, upc_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [FW_W-1:0]        fw_cnt_q, fw_cnt_d;
  logic                   jump_q, jump_d;
  logic                   halt_q, halt_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   rom_re_q, pc_en_q, pc_load_n_q, halted_q;

  logic [UPC_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [UPC_WIDTH-1:0]   stack_top;
  logic [UPC_WIDTH-1:0]   upc_inc;
  logic                   push_en;

  assign upc_inc = upc_q + UPC_WIDTH'(1);

  // Top-of-stack entry (index level-1); only consulted when level is non-zero.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (LVL_W'(i + 1) == level_q) stack_top = stack_q[i];
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    level_d   = level_q;
    fw_cnt_d  = fw_cnt_q;
    jump_d    = jump_q;
    halt_d    = halt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    retired_d = retired_q;
    push_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (halt_request) begin
          state_d = ST_HALTED;
        end else if (enable) begin
          state_d  = ST_FETCH_WAIT;
          fw_cnt_d = FETCH_LAT;
        end
      end

      // Counter holds the remaining wait cycles including the current one.
      ST_FETCH_WAIT: begin
        if (fw_cnt_q <= FW_W'(1)) begin
          state_d = ST_DISPATCH;
        end else begin
          fw_cnt_d = fw_cnt_q - FW_W'(1);
        end
      end

      // New instruction: any stack entries left by the previous one are dropped.
      ST_DISPATCH: begin
        upc_d   = dispatch_address;
        level_d = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!mem_ready) begin
          state_d = ST_STALL;
        end else if (uc_finish) begin
          retired_d = retired_q + COUNT_WIDTH'(1);
          jump_d    = uc_jump;
          halt_d    = halt_request;
          state_d   = ST_ADVANCE;
        end else if (uc_call) begin
          if (level_q == DEPTH_LVL) begin
            state_d = ST_FAULT;
            ovf_d   = 1'b1;
          end else begin
            push_en = 1'b1;
            upc_d   = uc_target;
            level_d = level_q + LVL_W'(1);
          end
        end else if (uc_return) begin
          if (level_q == '0) begin
            state_d = ST_FAULT;
            unf_d   = 1'b1;
          end else begin
            upc_d   = stack_top;
            level_d = level_q - LVL_W'(1);
          end
        end else if (uc_branch && branch_taken) begin
          upc_d = uc_target;
        end else begin
          upc_d = upc_inc;
        end
      end

      // Microword is ignored while stalled and re-evaluated once back in RUN.
      ST_STALL: begin
        if (mem_ready) state_d = ST_RUN;
      end

      ST_ADVANCE: begin
        if (halt_q) begin
          state_d = ST_HALTED;
        end else begin
          state_d  = ST_FETCH_WAIT;
          fw_cnt_d = FETCH_LAT;
        end
      end

      // HALTED and FAULT hold everything until reset.
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State and control registers; Moore outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      upc_q       <= '0;
      level_q     <= '0;
      fw_cnt_q    <= '0;
      jump_q      <= 1'b0;
      halt_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      retired_q   <= '0;
      rom_re_q    <= 1'b0;
      pc_en_q     <= 1'b0;
      pc_load_n_q <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      level_q     <= level_d;
      fw_cnt_q    <= fw_cnt_d;
      jump_q      <= jump_d;
      halt_q      <= halt_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      retired_q   <= retired_d;
      rom_re_q    <= (state_d == ST_RUN) || (state_d == ST_STALL);
      pc_en_q     <= (state_d == ST_ADVANCE) && !jump_d;
      pc_load_n_q <= !((state_d == ST_ADVANCE) && jump_d);
      halted_q    <= (state_d == ST_HALTED);
    end
  end

  // Call-stack storage; a push writes the slot at the current level.
  always_ff @(posedge clock) begin
    if (push_en) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (LVL_W'(i) == level_q) stack_q[i] <= upc_inc;
      end
    end
  end

  assign upc             = upc_q;
  assign rom_read_enable = rom_re_q;
  assign pc_enable       = pc_en_q;
  assign pc_load_n       = pc_load_n_q;
  assign state           = state_q;
  assign stack_level     = level_q;
  assign halted          = halted_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
  assign instr_retired   = retired_q;

endmodule

// File: doc/microcode_sequencer_stack.md
Name: microcode_sequencer_stack

Overview:
Parametrised successor to the execution driver and microcode sequencer pair. A single FSM owns the micro-PC (upc), a microcode call/return stack, a memory-stall handshake, a configurable instruction-fetch latency and a retired-instruction counter. It sits between the opcode translator ROM, the microcode ROM and the program counter. It drives upc directly to the microcode ROM address and drives PC enable/load strobes.

Parameters:
UPC_WIDTH, 16, micro-PC width; upc wraps modulo 2^UPC_WIDTH
STACK_DEPTH, 4, number of call-stack entries (>=1)
FETCH_LATENCY, 1, cycles waited after PC change before dispatch (1..15)
COUNT_WIDTH, 16, width of instr_retired

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  start request; sampled only in IDLE
halt_request  in  1  from halt check; sampled in IDLE and on finish
dispatch_address  in  UPC_WIDTH  microcode entry point from opcode translator
mem_ready  in  1  0 = memory busy, stall microcode
uc_finish  in  1  microword: instruction complete
uc_jump  in  1  microword: load PC instead of incrementing (qualifies uc_finish)
uc_call  in  1  microword: push upc+1, go to uc_target
uc_return  in  1  microword: pop into upc
uc_branch  in  1  microword: conditional micro-branch
branch_taken  in  1  condition for uc_branch
uc_target  in  UPC_WIDTH  call/branch target
upc  out  UPC_WIDTH  microcode ROM address
rom_read_enable  out  1  high in RUN and STALL only
pc_enable  out  1  PC increment strobe
pc_load_n  out  1  active-low PC load strobe
state  out  3  current FSM state encoding
stack_level  out  $clog2(STACK_DEPTH+1)  current stack occupancy
halted  out  1  high in HALTED
stack_overflow  out  1  sticky error flag
stack_underflow  out  1  sticky error flag
instr_retired  out  COUNT_WIDTH  count of finished instructions, wraps

Behaviour:
- Reset (any state, overrides everything):
  - state=IDLE, upc=0, stack_level=0, instr_retired=0.
  - All flags=0, pc_enable=0, pc_load_n=1, rom_read_enable=0.
- State encoding: IDLE=0, FETCH_WAIT=1, DISPATCH=2, RUN=3, STALL=4, ADVANCE=5, HALTED=6, FAULT=7.
- Strobes are Moore outputs. pc_enable=1 only in ADVANCE with latched jump=0. pc_load_n=0 only in ADVANCE with latched jump=1. At most one strobe is active, for exactly one cycle.
- IDLE:
  - halt_request=1 -> HALTED (halt has priority over enable).
  - else enable=1 -> FETCH_WAIT; no PC advance, so the first instruction is at the current PC.
- FETCH_WAIT: internal counter loads FETCH_LATENCY on entry; state exits to DISPATCH after exactly FETCH_LATENCY cycles in FETCH_WAIT.
- DISPATCH (1 cycle): upc<=dispatch_address, stack_level<=0 (leftover entries discarded) -> RUN.
- RUN: microword inputs are evaluated each cycle, with this priority:
  1. mem_ready=0 -> STALL; upc held; microword ignored.
  2. uc_finish: instr_retired+1; latch uc_jump and halt_request -> ADVANCE; upc held.
  3. uc_call:
     - stack_level==STACK_DEPTH -> FAULT, stack_overflow=1, no push, upc held.
     - else push upc+1 (wrapped), upc<=uc_target, level+1.
  4. uc_return:
     - level==0 -> FAULT, stack_underflow=1, upc held.
     - else upc<=top entry, level-1.
  5. uc_branch & branch_taken -> upc<=uc_target.
  6. otherwise upc<=upc+1, wrapping 2^UPC_WIDTH-1 -> 0.
- STALL: all microword inputs ignored, upc held. mem_ready=1 -> RUN; the same microword is re-evaluated in the RUN cycle.
- ADVANCE (1 cycle): strobe asserted; latched halt=1 -> HALTED, else -> FETCH_WAIT.
- enable is ignored outside IDLE. halt_request is ignored except in IDLE and on uc_finish.
- HALTED and FAULT are terminal until reset. In both: rom_read_enable=0, upc and counters frozen, strobes inactive.

Test Plan:
1. FETCH_LATENCY=1; reset, enable=1, dispatch_address=0x0010; microword at 0x10 plain, at 0x11 finish, uc_jump=0 -> states 0,1,2,3,3,5,1; upc 0x10 then 0x11; pc_enable high exactly 1 cycle; instr_retired=1.
2. At 0x20 call target 0x30; at 0x30 return -> upc sequence 0x20,0x30,0x21; stack_level 0,1,0.
3. STACK_DEPTH=2; three nested calls (0x20->0x30, 0x30->0x40, 0x40->0x50) -> third call gives state=7, stack_overflow=1, upc=0x40, rom_read_enable=0. A return at level 0 in a fresh run -> state=7, stack_underflow=1.
4. mem_ready=0 for 3 cycles while upc=0x12 -> state=4 for 3 cycles, upc=0x12 held; then RUN and upc=0x13.
5. finish with uc_jump=1 and halt_request=1 in the same cycle -> ADVANCE with pc_load_n=0 and pc_enable=0 for 1 cycle, then state=6, halted=1, stays halted with enable toggling; FETCH_LATENCY=3 run shows exactly 3 FETCH_WAIT cycles.
6. upc=0xFFFF plain microword -> upc=0x0000. Reset asserted mid-RUN with stack_level=1 -> next edge all outputs at reset values.
